// File: rtl/mem_slave_resp.sv
// Single-beat bus responder in front of a word-organised memory array.
// Each beat is captured, held for a fixed latency, then completed with a one-cycle ack.
module mem_slave_resp #(
  parameter int AW  = 14,
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_cyc,
  input  logic        s_we,
  input  logic [3:0]  s_strb,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_data_i,
  output logic [31:0] s_data_o,
  output logic        s_ack,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t        state;
  state_t        state_n;
  logic [3:0]    cnt;
  logic [3:0]    cnt_n;
  logic          capture;
  logic          access;

  logic [31:2]   cap_addr;
  logic          cap_we;
  logic [3:0]    cap_strb;
  logic [31:0]   cap_data;

  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   mem [2**AW];

  // Byte offset within a word carries no meaning on this bus.
  logic          unused_lsb;
  assign unused_lsb = ^s_addr[1:0];

  assign in_range = (cap_addr[31:AW+2] == '0);
  assign idx      = cap_addr[AW+1:2];
  assign s_ack    = (state == ACK);
  assign busy     = (state != IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    access  = 1'b0;
    case (state)
      IDLE: begin
        if (s_cyc) begin
          capture = 1'b1;
          cnt_n   = CNT_INIT;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (!s_cyc) begin
          state_n = IDLE;
        end else if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          access  = 1'b1;
          state_n = ACK;
        end
      end
      ACK: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      s_data_o <= 32'h0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (capture) begin
        cap_addr <= s_addr[31:2];
        cap_we   <= s_we;
        cap_strb <= s_strb;
        cap_data <= s_data_i;
      end
      if (access && !cap_we) begin
        s_data_o <= in_range ? mem[idx] : 32'h0;
      end
    end
  end

  // Array is never reset; a reset in flight suppresses the pending write.
  always_ff @(posedge clk) begin
    if (!rst && access && cap_we && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_strb[i]) begin
          mem[idx][8*i +: 8] <= cap_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_slave_resp.sv
// Bench for mem_slave_resp: vector table, corner sequences,
// and random beats against an associative-array memory model.
module tb_mem_slave_resp;

  localparam int AW  = 14;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_cyc;
  logic        s_we;
  logic [3:0]  s_strb;
  logic [31:0] s_addr;
  logic [31:0] s_data_i;
  logic [31:0] s_data_o;
  logic        s_ack;
  logic        busy;

  mem_slave_resp #(.AW(AW), .LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_cyc    (s_cyc),
    .s_we     (s_we),
    .s_strb   (s_strb),
    .s_addr   (s_addr),
    .s_data_i (s_data_i),
    .s_data_o (s_data_o),
    .s_ack    (s_ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [int];

  typedef struct {
    logic        we;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [13];
  logic [31:0] rd;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit oor(input logic [31:0] a);
    logic [31:0] hi;
    hi = a >> (AW + 2);
    return hi != 0;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << AW) - 1));
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (oor(a)) return 32'h0;
    if (!ref_mem.exists(widx(a))) return 32'h0;
    return ref_mem[widx(a)];
  endfunction

  function automatic void model_write(input logic [31:0] a,
                                      input logic [3:0] strb,
                                      input logic [31:0] d);
    logic [31:0] w;
    if (oor(a)) return;
    w = model_read(a);
    for (int i = 0; i < 4; i++)
      if (strb[i]) w[8*i +: 8] = d[8*i +: 8];
    ref_mem[widx(a)] = w;
  endfunction

  // One beat; exp_lat counts edges from the call to the ack cycle.
  task automatic beat(input logic we, input logic [3:0] strb,
                      input logic [31:0] addr, input logic [31:0] data,
                      input int exp_lat, input bit keep,
                      output logic [31:0] rdo);
    int n;
    bit got;
    s_cyc    = 1'b1;
    s_we     = we;
    s_strb   = strb;
    s_addr   = addr;
    s_data_i = data;
    n   = 0;
    got = 0;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (s_ack) got = 1;
      else if (n == 1 && exp_lat == LAT + 1) begin
        s_addr   = ~addr;
        s_data_i = ~data;
      end
    end
    chk("ack_latency", 32'(n), 32'(exp_lat));
    rdo = s_data_o;
    if (we) model_write(addr, strb, data);
    if (!keep) begin
      s_cyc = 1'b0;
      @(posedge clk);
      #1;
      chk("ack_pulse", {30'b0, s_ack, busy}, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 4'hF, 32'h0000_0100, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 4'h0, 32'h0000_0100, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b1, 4'hF, 32'h0000_0040, 32'h11223344, 32'h0};
    tbl[3]  = '{1'b1, 4'h5, 32'h0000_0040, 32'hAABBCCDD, 32'h0};
    tbl[4]  = '{1'b0, 4'hF, 32'h0000_0040, 32'h0,        32'h11BB33DD};
    tbl[5]  = '{1'b1, 4'hF, 32'h0000_0044, 32'hCAFEF00D, 32'h0};
    tbl[6]  = '{1'b1, 4'h0, 32'h0000_0044, 32'hFFFFFFFF, 32'h0};
    tbl[7]  = '{1'b0, 4'h0, 32'h0000_0044, 32'h0,        32'hCAFEF00D};
    tbl[8]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h0BADC0DE, 32'h0};
    tbl[9]  = '{1'b0, 4'h0, 32'h0010_0000, 32'h0,        32'h0};
    tbl[10] = '{1'b1, 4'hF, 32'h0010_0000, 32'h12345678, 32'h0};
    tbl[11] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,        32'h0BADC0DE};
    tbl[12] = '{1'b0, 4'h3, 32'h0000_0103, 32'h0,        32'hDEADBEEF};

    rst      = 1'b1;
    s_cyc    = 1'b0;
    s_we     = 1'b0;
    s_strb   = 4'h0;
    s_addr   = 32'h0;
    s_data_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_ack", {31'b0, s_ack}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_data", s_data_o, 32'h0);

    for (int i = 0; i < 13; i++) begin
      beat(tbl[i].we, tbl[i].strb, tbl[i].addr, tbl[i].wdata,
           LAT + 1, 1'b0, rd);
      if (!tbl[i].we) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
    end

    // burst fill: s_cyc held, address advanced in each ack cycle
    for (int i = 0; i < 8; i++)
      beat(1'b1, 4'hF, 32'h200 + 32'(4*i), $urandom, LAT + 1, 1'b0, rd);
    for (int i = 0; i < 8; i++) begin
      beat(1'b0, 4'h0, 32'h200 + 32'(4*i), 32'h0,
           (i == 0) ? LAT + 1 : LAT + 2, i != 7, rd);
      chk($sformatf("burst%0d_rdata", i), rd, model_read(32'h200 + 32'(4*i)));
    end

    // abort: s_cyc dropped while BUSY
    beat(1'b1, 4'hF, 32'h80, 32'h5555AAAA, LAT + 1, 1'b0, rd);
    s_cyc    = 1'b1;
    s_we     = 1'b1;
    s_strb   = 4'hF;
    s_addr   = 32'h80;
    s_data_i = 32'h01020304;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'b0, busy}, 32'h1);
    s_cyc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("abort_quiet", {30'b0, s_ack, busy}, 32'h0);
    end
    beat(1'b0, 4'h0, 32'h80, 32'h0, LAT + 1, 1'b0, rd);
    chk("abort_rdata", rd, 32'h5555AAAA);

    // reset while a write is in flight
    beat(1'b1, 4'hF, 32'h84, 32'h600DF00D, LAT + 1, 1'b0, rd);
    s_cyc    = 1'b1;
    s_we     = 1'b1;
    s_strb   = 4'hF;
    s_addr   = 32'h84;
    s_data_i = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_inflight", {30'b0, s_ack, busy}, 32'h0);
    chk("rst_inflight_data", s_data_o, 32'h0);
    rst   = 1'b0;
    s_cyc = 1'b0;
    @(posedge clk);
    #1;
    beat(1'b0, 4'h0, 32'h84, 32'h0, LAT + 1, 1'b0, rd);
    chk("rst_rdata", rd, 32'h600DF00D);

    // random traffic in a preloaded window, some out of range
    for (int i = 0; i < 16; i++)
      beat(1'b1, 4'hF, 32'h300 + 32'(4*i), $urandom, LAT + 1, 1'b0, rd);
    for (int i = 0; i < 80; i++) begin
      logic        we;
      logic [3:0]  strb;
      logic [31:0] a;
      logic [31:0] d;
      we   = 1'($urandom_range(0, 1));
      strb = 4'($urandom_range(0, 15));
      a    = 32'h300 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      d    = $urandom;
      beat(we, strb, a, d, LAT + 1, 1'b0, rd);
      if (!we) chk($sformatf("rand%0d_rdata", i), rd, model_read(a));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
